// File: rtl/micro_program_pkg.sv
// Shared types and constants for the SM2201 CAMAC strobe microprogram sequencer.
package micro_program_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE1,
        GAP,
        STROBE2,
        HOLD
    } state_t;

    localparam int T1_DEFAULT  = 4;
    localparam int GAP_DEFAULT = 2;
    localparam int T2_DEFAULT  = 4;

    localparam logic [1:0] STATUS_ADDR = 2'b11;

    // The phase counter counts down to zero, so a phase of N clks loads N-1.
    function automatic logic [7:0] phase_load(input int cycles);
        return 8'(cycles - 1);
    endfunction

endpackage

// File: rtl/micro_program_automate_sync_2ff.sv
// Two-flop synchroniser for one asynchronous board input.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/micro_program_automate.sv
// Microprogram sequencer: turns an ISA write into a c1 / gap / c2 CAMAC strobe
// sequence, holding rdy low while busy and latching the X response.
module micro_program_automate
    import micro_program_pkg::*;
#(
    parameter int T1_CYCLES  = T1_DEFAULT,
    parameter int GAP_CYCLES = GAP_DEFAULT,
    parameter int T2_CYCLES  = T2_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] a,
    input  logic       w,
    input  logic       sel,
    input  logic       ie,
    input  logic       cx1,
    input  logic       tim,
    output logic       rdy,
    output logic       c1,
    output logic       c2,
    output logic       sel2,
    output logic       x0,
    output logic       x1
);

    logic       w_s, sel_s, ie_s, cx1_s, tim_s;
    logic       w_q;
    logic       w_rise;
    state_t     state;
    logic [7:0] cnt;
    logic [1:0] a_r;

    sync_2ff u_sync_w   (.clk(clk), .reset(reset), .d(w),   .q(w_s));
    sync_2ff u_sync_sel (.clk(clk), .reset(reset), .d(sel), .q(sel_s));
    sync_2ff u_sync_ie  (.clk(clk), .reset(reset), .d(ie),  .q(ie_s));
    sync_2ff u_sync_cx1 (.clk(clk), .reset(reset), .d(cx1), .q(cx1_s));
    sync_2ff u_sync_tim (.clk(clk), .reset(reset), .d(tim), .q(tim_s));

    assign w_rise = w_s & ~w_q;

    // Outputs are set on the edge that enters each state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
            a_r   <= 2'b00;
            w_q   <= 1'b0;
            rdy   <= 1'b1;
            c1    <= 1'b0;
            c2    <= 1'b0;
            sel2  <= 1'b0;
            x0    <= 1'b0;
            x1    <= 1'b0;
        end else begin
            w_q <= w_s;
            x0  <= x1 & ie_s;
            if (state != IDLE && state != HOLD && !tim_s) begin
                state <= IDLE;
                cnt   <= 8'd0;
                rdy   <= 1'b1;
                c1    <= 1'b0;
                c2    <= 1'b0;
                sel2  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (tim_s && sel_s && w_rise) begin
                            state <= SETUP;
                            a_r   <= a;
                            cnt   <= 8'd0;
                            rdy   <= 1'b0;
                            sel2  <= (a == STATUS_ADDR);
                        end
                    end
                    SETUP: begin
                        state <= STROBE1;
                        c1    <= 1'b1;
                        sel2  <= (a_r == STATUS_ADDR);
                        cnt   <= phase_load(T1_CYCLES);
                    end
                    STROBE1: begin
                        if (cnt == 8'd0) begin
                            state <= GAP;
                            c1    <= 1'b0;
                            cnt   <= phase_load(GAP_CYCLES);
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    GAP: begin
                        if (cnt == 8'd0) begin
                            state <= STROBE2;
                            c2    <= 1'b1;
                            cnt   <= phase_load(T2_CYCLES);
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    STROBE2: begin
                        if (cnt == 8'd0) begin
                            state <= HOLD;
                            c2    <= 1'b0;
                            sel2  <= 1'b0;
                            rdy   <= 1'b1;
                            x1    <= cx1_s;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    HOLD: begin
                        if (!w_s) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_micro_program_automate.sv
// Randomised self-checking bench: compares strobe/ready waveforms with timing derived from the phase lengths.
module tb_micro_program_automate;

    localparam int T1   = 4;
    localparam int GP   = 2;
    localparam int T2   = 4;
    localparam int BUSY = 1 + T1 + GP + T2;
    localparam int FIRST = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] a = 2'b00;
    logic       w = 1'b0, sel = 1'b0, ie = 1'b0, cx1 = 1'b0, tim = 1'b0;
    logic       rdy, c1, c2, sel2, x0, x1;

    int tests = 0;
    int fails = 0;

    int         tim_drop_k = 0, sel_drop_k = 0, a_chg_k = 0, wtog_k = 0;
    logic [1:0] a_chg_val = 2'b00;
    logic       mx1 = 1'b0;

    logic [63:0] tr_c1, tr_c2, tr_rdy, tr_sel2;
    logic [63:0] ex_c1, ex_c2, ex_rdy, ex_sel2;

    micro_program_automate #(.T1_CYCLES(T1), .GAP_CYCLES(GP), .T2_CYCLES(T2)) dut (
        .clk(clk), .reset(reset), .a(a), .w(w), .sel(sel), .ie(ie), .cx1(cx1), .tim(tim),
        .rdy(rdy), .c1(c1), .c2(c2), .sel2(sel2), .x0(x0), .x1(x1)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Raises w, then records one sample per clk just after each rising edge.
    task automatic capture(input int n, input int hold);
        tr_c1 = '0; tr_c2 = '0; tr_rdy = '0; tr_sel2 = '0;
        w = 1'b1;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            tr_c1[k] = c1; tr_c2[k] = c2; tr_rdy[k] = rdy; tr_sel2[k] = sel2;
            if (k == hold) w = 1'b0;
            if (wtog_k != 0) begin
                if (k == wtog_k || k == wtog_k + 4) w = 1'b0;
                if (k == wtog_k + 2 || k == wtog_k + 6) w = 1'b1;
            end
            if (k == tim_drop_k) tim = 1'b0;
            if (k == sel_drop_k) sel = 1'b0;
            if (k == a_chg_k) a = a_chg_val;
        end
        w = 1'b0;
    endtask

    // Expected waveform: busy window starts at sample 3, phases follow back to back.
    task automatic build_expect(input logic [1:0] addr, input int cut, input int n, input bit starts);
        ex_c1 = '0; ex_c2 = '0; ex_rdy = '0; ex_sel2 = '0;
        for (int k = 1; k <= n; k++) begin
            bit busy;
            busy = starts && k >= FIRST && k < FIRST + BUSY && (cut == 0 || k < cut);
            ex_rdy[k]  = !busy;
            ex_sel2[k] = busy && (addr == 2'b11);
            ex_c1[k]   = busy && k >= FIRST + 1 && k <= FIRST + T1;
            ex_c2[k]   = busy && k > FIRST + T1 + GP && k <= FIRST + T1 + GP + T2;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            w = ~w;
            tests++;
            if ({rdy, c1, c2, sel2, x0, x1} !== 6'b100000) begin
                fails++;
                $display("[TB] FAIL reset_out k=%0d got %b want 100000", k, {rdy, c1, c2, sel2, x0, x1});
            end
        end
        reset = 1'b0; tim = 1'b0; sel = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            w = ~w;
            tests++;
            if ({rdy, c1, c2, sel2} !== 4'b1000) begin
                fails++;
                $display("[TB] FAIL tim_low_idle k=%0d got %b want 1000", k, {rdy, c1, c2, sel2});
            end
        end
        w = 1'b0; tim = 1'b1;
        idle(4);
    endtask

    task automatic test_basic();
        a = 2'b00; cx1 = 1'b0; ie = 1'b0;
        idle(3);
        capture(20, 20);
        build_expect(2'b00, 0, 20, 1'b1);
        tests++;
        if ({tr_c1, tr_c2} !== {ex_c1, ex_c2}) begin
            fails++;
            $display("[TB] FAIL basic_strobes got c1=%h c2=%h want c1=%h c2=%h", tr_c1, tr_c2, ex_c1, ex_c2);
        end
        tests++;
        if ({tr_rdy, tr_sel2} !== {ex_rdy, ex_sel2}) begin
            fails++;
            $display("[TB] FAIL basic_status got rdy=%h sel2=%h want rdy=%h sel2=%h", tr_rdy, tr_sel2, ex_rdy, ex_sel2);
        end
        mx1 = 1'b0;
        idle(4);
    endtask

    task automatic test_status_hold();
        a = 2'b11; a_chg_k = 5; a_chg_val = 2'b00;
        capture(35, 35);
        a_chg_k = 0;
        build_expect(2'b11, 0, 35, 1'b1);
        tests++;
        if ({tr_c1, tr_c2} !== {ex_c1, ex_c2}) begin
            fails++;
            $display("[TB] FAIL status_strobes got c1=%h c2=%h want c1=%h c2=%h", tr_c1, tr_c2, ex_c1, ex_c2);
        end
        tests++;
        if ({tr_rdy, tr_sel2} !== {ex_rdy, ex_sel2}) begin
            fails++;
            $display("[TB] FAIL status_sel2_hold got rdy=%h sel2=%h want rdy=%h sel2=%h", tr_rdy, tr_sel2, ex_rdy, ex_sel2);
        end
        idle(4);
        capture(20, 20);
        build_expect(2'b00, 0, 20, 1'b1);
        tests++;
        if ({tr_c1, tr_c2, tr_rdy, tr_sel2} !== {ex_c1, ex_c2, ex_rdy, ex_sel2}) begin
            fails++;
            $display("[TB] FAIL after_hold_restart got c1=%h c2=%h rdy=%h sel2=%h want c1=%h c2=%h rdy=%h sel2=%h",
                     tr_c1, tr_c2, tr_rdy, tr_sel2, ex_c1, ex_c2, ex_rdy, ex_sel2);
        end
        idle(4);
    endtask

    task automatic test_xflag();
        cx1 = 1'b1; ie = 1'b1; a = 2'b01;
        idle(3);
        capture(20, 20);
        mx1 = 1'b1;
        idle(2);
        tests++;
        if ({x1, x0} !== {mx1, mx1 & ie}) begin
            fails++;
            $display("[TB] FAIL xflag_set got x1x0=%b want %b", {x1, x0}, {mx1, mx1 & ie});
        end
        ie = 1'b0;
        idle(3);
        tests++;
        if ({x1, x0} !== {mx1, 1'b0}) begin
            fails++;
            $display("[TB] FAIL xflag_ie_drop got x1x0=%b want %b", {x1, x0}, {mx1, 1'b0});
        end
        cx1 = 1'b0;
        idle(2);
        capture(20, 20);
        mx1 = 1'b0;
        idle(2);
        tests++;
        if (x1 !== mx1) begin
            fails++;
            $display("[TB] FAIL xflag_clear got x1=%b want %b", x1, mx1);
        end
    endtask

    task automatic test_abort();
        cx1 = 1'b1; ie = 1'b1;
        idle(3);
        capture(20, 20);
        mx1 = 1'b1;
        idle(3);
        cx1 = 1'b0;
        tim_drop_k = 5;
        capture(20, 20);
        tim_drop_k = 0;
        build_expect(2'b01, 5 + 3, 20, 1'b1);
        tests++;
        if ({tr_c1, tr_c2, tr_rdy} !== {ex_c1, ex_c2, ex_rdy}) begin
            fails++;
            $display("[TB] FAIL abort_wave got c1=%h c2=%h rdy=%h want c1=%h c2=%h rdy=%h",
                     tr_c1, tr_c2, tr_rdy, ex_c1, ex_c2, ex_rdy);
        end
        tests++;
        if (x1 !== mx1) begin
            fails++;
            $display("[TB] FAIL abort_x1_kept got x1=%b want %b", x1, mx1);
        end
        tim = 1'b1;
        idle(4);
    endtask

    task automatic test_back_to_back();
        a = 2'b11; sel = 1'b1;
        wtog_k = 4; sel_drop_k = 5;
        capture(24, 16);
        wtog_k = 0; sel_drop_k = 0;
        build_expect(2'b11, 0, 24, 1'b1);
        tests++;
        if ({tr_c1, tr_c2, tr_rdy, tr_sel2} !== {ex_c1, ex_c2, ex_rdy, ex_sel2}) begin
            fails++;
            $display("[TB] FAIL ignored_edges got c1=%h c2=%h rdy=%h sel2=%h want c1=%h c2=%h rdy=%h sel2=%h",
                     tr_c1, tr_c2, tr_rdy, tr_sel2, ex_c1, ex_c2, ex_rdy, ex_sel2);
        end
        idle(4);
        capture(16, 16);
        build_expect(2'b11, 0, 16, 1'b0);
        tests++;
        if ({tr_c1, tr_c2, tr_rdy, tr_sel2} !== {ex_c1, ex_c2, ex_rdy, ex_sel2}) begin
            fails++;
            $display("[TB] FAIL sel_low_no_cycle got c1=%h c2=%h rdy=%h want c1=%h c2=%h rdy=%h",
                     tr_c1, tr_c2, tr_rdy, ex_c1, ex_c2, ex_rdy);
        end
        sel = 1'b1;
        idle(4);
    endtask

    task automatic test_random();
        for (int i = 0; i < 10; i++) begin
            logic [1:0] ra;
            int         hold;
            ra   = 2'($urandom_range(0, 3));
            hold = int'($urandom_range(1, 30));
            a    = ra;
            cx1  = 1'($urandom_range(0, 1));
            ie   = 1'($urandom_range(0, 1));
            idle(3);
            capture(24, hold);
            mx1 = cx1;
            build_expect(ra, 0, 24, 1'b1);
            tests++;
            if ({tr_c1, tr_c2, tr_rdy, tr_sel2} !== {ex_c1, ex_c2, ex_rdy, ex_sel2}) begin
                fails++;
                $display("[TB] FAIL random_wave i=%0d got c1=%h c2=%h rdy=%h sel2=%h want c1=%h c2=%h rdy=%h sel2=%h",
                         i, tr_c1, tr_c2, tr_rdy, tr_sel2, ex_c1, ex_c2, ex_rdy, ex_sel2);
            end
            idle(4);
            tests++;
            if ({x1, x0} !== {mx1, mx1 & ie}) begin
                fails++;
                $display("[TB] FAIL random_xflag i=%0d got x1x0=%b want %b", i, {x1, x0}, {mx1, mx1 & ie});
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_status_hold();
        test_xflag();
        test_abort();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
